// File: rtl/cache_axi_arbiter_pkg.sv
// Shared FSM states, owner encoding and fixed AXI field values for the
// icache/dcache to single-AXI-master arbiter.
package cache_axi_arbiter_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ACTIVE = 2'd1,
    W_RESP   = 2'd2
  } wr_state_t;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_t;

  typedef enum logic [2:0] {
    AXI_SIZE_1B = 3'b000,
    AXI_SIZE_2B = 3'b001,
    AXI_SIZE_4B = 3'b010
  } axi_size_t;

  localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
  localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
  localparam logic [2:0] AXI_PROT_NONE   = 3'b000;

  localparam logic [3:0] INST_ID_DEF = 4'd0;
  localparam logic [3:0] DATA_ID_DEF = 4'd1;

endpackage

// File: rtl/cache_axi_arbiter_read_mux.sv
// R-channel steering: forwards the AXI read beat to whichever cache owns the
// outstanding read, zero latency; rready follows the owner's r_ready.
module axi_read_mux (
  input  logic        i_active,
  input  logic        i_owner_data,
  input  logic        i_rvalid,
  input  logic [31:0] i_rdata,
  input  logic        i_rlast,
  input  logic        i_inst_r_ready,
  input  logic        i_data_r_ready,
  output logic        o_rready,
  output logic        o_inst_r_valid,
  output logic [31:0] o_inst_r_data,
  output logic        o_inst_r_last,
  output logic        o_data_r_valid,
  output logic [31:0] o_data_r_data,
  output logic        o_data_r_last
);

  logic w_to_inst;
  logic w_to_data;

  assign w_to_inst = i_active && !i_owner_data;
  assign w_to_data = i_active && i_owner_data;

  assign o_rready       = (w_to_inst && i_inst_r_ready) || (w_to_data && i_data_r_ready);

  assign o_inst_r_valid = w_to_inst && i_rvalid;
  assign o_inst_r_data  = i_rdata;
  assign o_inst_r_last  = w_to_inst && i_rlast;

  assign o_data_r_valid = w_to_data && i_rvalid;
  assign o_data_r_data  = i_rdata;
  assign o_data_r_last  = w_to_data && i_rlast;

endmodule

// File: rtl/cache_axi_arbiter.sv
// Arbitrates icache/dcache reads (round-robin, one outstanding) onto one AXI master
// and passes dcache writes through; read and write paths run independently.
module cache_axi_arbiter
  import cache_axi_arbiter_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEF,
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic        clock,
  input  logic        reset,
  // icache read
  input  logic        inst_ar_valid,
  output logic        inst_ar_ready,
  input  logic [31:0] inst_ar_addr,
  input  logic [7:0]  inst_ar_len,
  input  logic [2:0]  inst_ar_size,
  output logic        inst_r_valid,
  input  logic        inst_r_ready,
  output logic [31:0] inst_r_data,
  output logic        inst_r_last,
  // dcache read
  input  logic        data_ar_valid,
  output logic        data_ar_ready,
  input  logic [31:0] data_ar_addr,
  input  logic [7:0]  data_ar_len,
  input  logic [2:0]  data_ar_size,
  output logic        data_r_valid,
  input  logic        data_r_ready,
  output logic [31:0] data_r_data,
  output logic        data_r_last,
  // dcache write
  input  logic        data_aw_valid,
  output logic        data_aw_ready,
  input  logic [31:0] data_aw_addr,
  input  logic [7:0]  data_aw_len,
  input  logic [2:0]  data_aw_size,
  input  logic        data_w_valid,
  output logic        data_w_ready,
  input  logic [31:0] data_w_data,
  input  logic [3:0]  data_w_strb,
  input  logic        data_w_last,
  output logic        data_b_valid,
  input  logic        data_b_ready,
  // AXI master
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  // ---------------- read path ----------------
  rd_state_t   r_rd_state;
  rd_state_t   w_rd_next;
  owner_t      r_owner;
  owner_t      w_grant;
  logic [31:0] r_ar_addr;
  logic [7:0]  r_ar_len;
  logic [2:0]  r_ar_size;
  logic [3:0]  r_ar_id;
  logic        w_any_req;
  logic        w_ar_hs;
  logic        w_r_done;
  logic        w_rready;

  assign w_any_req = inst_ar_valid || data_ar_valid;

  // r_owner doubles as "last granted", so after reset (INST) data wins a tie.
  always_comb begin
    w_grant = OWNER_INST;
    if (inst_ar_valid && data_ar_valid) begin
      w_grant = (r_owner == OWNER_INST) ? OWNER_DATA : OWNER_INST;
    end else if (data_ar_valid) begin
      w_grant = OWNER_DATA;
    end
  end

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_any_req) w_rd_next = R_ADDR;
      R_ADDR:  if (arready)   w_rd_next = R_DATA;
      R_DATA:  if (w_r_done)  w_rd_next = R_IDLE;
      default: w_rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_state <= R_IDLE;
      r_owner    <= OWNER_INST;
      r_ar_addr  <= 32'd0;
      r_ar_len   <= 8'd0;
      r_ar_size  <= 3'd0;
      r_ar_id    <= 4'd0;
    end else begin
      r_rd_state <= w_rd_next;
      if (r_rd_state == R_IDLE && w_any_req) begin
        r_owner <= w_grant;
        if (w_grant == OWNER_DATA) begin
          r_ar_addr <= data_ar_addr;
          r_ar_len  <= data_ar_len;
          r_ar_size <= data_ar_size;
          r_ar_id   <= DATA_ID;
        end else begin
          r_ar_addr <= inst_ar_addr;
          r_ar_len  <= inst_ar_len;
          r_ar_size <= inst_ar_size;
          r_ar_id   <= INST_ID;
        end
      end
    end
  end

  assign arvalid = !reset && (r_rd_state == R_ADDR);
  assign arid    = r_ar_id;
  assign araddr  = r_ar_addr;
  assign arlen   = r_ar_len;
  assign arsize  = r_ar_size;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK_NORMAL;
  assign arcache = AXI_CACHE_NONE;
  assign arprot  = AXI_PROT_NONE;

  assign w_ar_hs       = arvalid && arready;
  assign inst_ar_ready = w_ar_hs && (r_owner == OWNER_INST);
  assign data_ar_ready = w_ar_hs && (r_owner == OWNER_DATA);

  // rid is not compared: only one read is ever outstanding.
  axi_read_mux u_read_mux (
    .i_active       (!reset && (r_rd_state == R_DATA)),
    .i_owner_data   (r_owner == OWNER_DATA),
    .i_rvalid       (rvalid),
    .i_rdata        (rdata),
    .i_rlast        (rlast),
    .i_inst_r_ready (inst_r_ready),
    .i_data_r_ready (data_r_ready),
    .o_rready       (w_rready),
    .o_inst_r_valid (inst_r_valid),
    .o_inst_r_data  (inst_r_data),
    .o_inst_r_last  (inst_r_last),
    .o_data_r_valid (data_r_valid),
    .o_data_r_data  (data_r_data),
    .o_data_r_last  (data_r_last)
  );

  assign rready   = w_rready;
  assign w_r_done = rvalid && w_rready && rlast;

  // ---------------- write path ----------------
  wr_state_t r_wr_state;
  wr_state_t w_wr_next;
  logic      r_aw_done;
  logic      r_w_done;
  logic      w_wr_active;
  logic      w_aw_hs;
  logic      w_wlast_hs;
  logic      w_b_hs;

  assign w_wr_active = !reset && (r_wr_state == W_ACTIVE);

  assign awvalid       = w_wr_active && data_aw_valid && !r_aw_done;
  assign data_aw_ready = w_wr_active && awready && !r_aw_done;
  assign awid          = DATA_ID;
  assign awaddr        = data_aw_addr;
  assign awlen         = data_aw_len;
  assign awsize        = data_aw_size;
  assign awburst       = AXI_BURST_INCR;
  assign awlock        = AXI_LOCK_NORMAL;
  assign awcache       = AXI_CACHE_NONE;
  assign awprot        = AXI_PROT_NONE;

  // Beats after wlast are held off so an early wlast cannot leak into the next burst.
  assign wvalid       = w_wr_active && data_w_valid && !r_w_done;
  assign data_w_ready = w_wr_active && wready && !r_w_done;
  assign wid          = DATA_ID;
  assign wdata        = data_w_data;
  assign wstrb        = data_w_strb;
  assign wlast        = data_w_last;

  assign bready       = !reset && (r_wr_state == W_RESP) && data_b_ready;
  assign data_b_valid = !reset && (r_wr_state == W_RESP) && bvalid;

  assign w_aw_hs    = awvalid && awready;
  assign w_wlast_hs = wvalid && wready && data_w_last;
  assign w_b_hs     = bready && bvalid;

  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      W_IDLE:   if (data_aw_valid) w_wr_next = W_ACTIVE;
      W_ACTIVE: if ((r_aw_done || w_aw_hs) && (r_w_done || w_wlast_hs)) w_wr_next = W_RESP;
      W_RESP:   if (w_b_hs) w_wr_next = W_IDLE;
      default:  w_wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_state <= W_IDLE;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      r_wr_state <= w_wr_next;
      if (w_b_hs) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs)    r_aw_done <= 1'b1;
        if (w_wlast_hs) r_w_done  <= 1'b1;
      end
    end
  end

  logic w_unused;
  assign w_unused = ^{rid, rresp, bid, bresp};

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: bench plays both caches and the AXI slave.
module tb_cache_axi_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        inst_ar_valid, inst_ar_ready;
  logic [31:0] inst_ar_addr;
  logic [7:0]  inst_ar_len;
  logic [2:0]  inst_ar_size;
  logic        inst_r_valid, inst_r_ready, inst_r_last;
  logic [31:0] inst_r_data;
  logic        data_ar_valid, data_ar_ready;
  logic [31:0] data_ar_addr;
  logic [7:0]  data_ar_len;
  logic [2:0]  data_ar_size;
  logic        data_r_valid, data_r_ready, data_r_last;
  logic [31:0] data_r_data;
  logic        data_aw_valid, data_aw_ready;
  logic [31:0] data_aw_addr;
  logic [7:0]  data_aw_len;
  logic [2:0]  data_aw_size;
  logic        data_w_valid, data_w_ready, data_w_last;
  logic [31:0] data_w_data;
  logic [3:0]  data_w_strb;
  logic        data_b_valid, data_b_ready;
  logic [3:0]  arid, arcache, awid, awcache, wid, wstrb, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_err = 0;
  int n_chk = 0;
  int pulses, r_got, rbeat, wb, b_cnt;
  logic ar_seen, aw_seen, wl_seen;

  always #5 clock = ~clock;

  cache_axi_arbiter dut (
    .clock(clock), .reset(reset),
    .inst_ar_valid(inst_ar_valid), .inst_ar_ready(inst_ar_ready), .inst_ar_addr(inst_ar_addr),
    .inst_ar_len(inst_ar_len), .inst_ar_size(inst_ar_size),
    .inst_r_valid(inst_r_valid), .inst_r_ready(inst_r_ready), .inst_r_data(inst_r_data), .inst_r_last(inst_r_last),
    .data_ar_valid(data_ar_valid), .data_ar_ready(data_ar_ready), .data_ar_addr(data_ar_addr),
    .data_ar_len(data_ar_len), .data_ar_size(data_ar_size),
    .data_r_valid(data_r_valid), .data_r_ready(data_r_ready), .data_r_data(data_r_data), .data_r_last(data_r_last),
    .data_aw_valid(data_aw_valid), .data_aw_ready(data_aw_ready), .data_aw_addr(data_aw_addr),
    .data_aw_len(data_aw_len), .data_aw_size(data_aw_size),
    .data_w_valid(data_w_valid), .data_w_ready(data_w_ready), .data_w_data(data_w_data),
    .data_w_strb(data_w_strb), .data_w_last(data_w_last),
    .data_b_valid(data_b_valid), .data_b_ready(data_b_ready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {20'd0, arvalid, awvalid, wvalid, rready, bready, inst_ar_ready, data_ar_ready,
              data_aw_ready, data_w_ready, inst_r_valid, data_r_valid, data_b_valid}, 32'd0);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {inst_ar_valid, inst_ar_addr, inst_ar_len, inst_ar_size, inst_r_ready} = '0;
    {data_ar_valid, data_ar_addr, data_ar_len, data_ar_size, data_r_ready} = '0;
    {data_aw_valid, data_aw_addr, data_aw_len, data_aw_size} = '0;
    {data_w_valid, data_w_data, data_w_strb, data_w_last, data_b_ready} = '0;
    {arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid} = '0;

    // reset: quiet during and one cycle after
    smp; chk_quiet("rst_during");
    cyc; reset = 1'b0;
    smp; chk_quiet("rst_after");
    cyc;

    // inst-only 8-beat read
    inst_ar_valid = 1; inst_ar_addr = 32'hBFC0_0000; inst_ar_len = 8'd7; inst_ar_size = 3'd2;
    smp; chk("t28_idle_arvalid", arvalid, 0); chk("t28_idle_ar_ready", inst_ar_ready, 0);
    cyc; arready = 1;
    smp;
    chk("t28_arvalid", arvalid, 1); chk("t28_arid", arid, 0); chk("t28_araddr", araddr, 32'hBFC0_0000);
    chk("t28_arlen", arlen, 7); chk("t28_arsize", arsize, 2); chk("t28_arburst", arburst, 1);
    chk("t28_arconst", {arlock, arcache, arprot}, 0);
    chk("t28_inst_ar_ready", inst_ar_ready, 1); chk("t28_data_ar_ready", data_ar_ready, 0);
    cyc; inst_ar_valid = 0; arready = 0;
    for (int i = 0; i < 8; i++) begin
      rvalid = 1; rid = 0; rdata = 32'hC000_0000 + i; rlast = (i == 7); inst_r_ready = 1;
      smp;
      chk("t28_r_valid", inst_r_valid, 1); chk("t28_r_data", inst_r_data, 32'hC000_0000 + i);
      chk("t28_r_last", inst_r_last, (i == 7) ? 1 : 0); chk("t28_data_r_valid", data_r_valid, 0);
      chk("t28_rready", rready, 1);
      cyc;
    end
    rvalid = 0; rlast = 0;
    smp; chk("t28_back_idle", {arvalid, rready, inst_r_valid}, 0);
    cyc;

    // fresh reset, then simultaneous requests: data first
    reset = 1;
    smp; chk_quiet("t29_rst");
    cyc; reset = 0;
    inst_ar_valid = 1; inst_ar_addr = 32'h0000_1000; inst_ar_len = 0; inst_ar_size = 2;
    data_ar_valid = 1; data_ar_addr = 32'h0000_2000; data_ar_len = 1; data_ar_size = 2;
    smp; chk("t29_idle_readies", {inst_ar_ready, data_ar_ready}, 0);
    cyc; arready = 1;
    smp;
    chk("t29_arid", arid, 1); chk("t29_araddr", araddr, 32'h2000); chk("t29_arlen", arlen, 1);
    chk("t29_data_ar_ready", data_ar_ready, 1); chk("t29_inst_ar_ready", inst_ar_ready, 0);
    cyc; data_ar_valid = 0; arready = 0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1; rid = 1; rdata = 32'hD000_0000 + i; rlast = (i == 1); data_r_ready = 1;
      smp;
      chk("t29_data_r_valid", data_r_valid, 1); chk("t29_data_r_data", data_r_data, 32'hD000_0000 + i);
      chk("t29_data_r_last", data_r_last, (i == 1) ? 1 : 0);
      chk("t29_inst_r_valid", inst_r_valid, 0); chk("t29_inst_pending", inst_ar_ready, 0);
      cyc;
    end
    rvalid = 0; rlast = 0;
    smp; chk("t29_idle_gap", arvalid, 0);
    cyc;

    // inst request now granted; arready held off 5 cycles
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      arready = 0;
      smp;
      chk("t30_arvalid", arvalid, 1); chk("t30_arid", arid, 0); chk("t30_araddr", araddr, 32'h1000);
      pulses += int'(inst_ar_ready) + int'(data_ar_ready);
      cyc;
    end
    arready = 1;
    smp;
    chk("t30_arvalid_hs", arvalid, 1); chk("t30_inst_ar_ready_hs", inst_ar_ready, 1);
    pulses += int'(inst_ar_ready) + int'(data_ar_ready);
    cyc; inst_ar_valid = 0; arready = 0;
    chk("t30_pulses", pulses, 1);
    // response carries an unexpected rid; still goes to the owner
    rvalid = 1; rid = 4'd9; rdata = 32'h0000_00EE; rlast = 1; inst_r_ready = 1;
    smp;
    chk("t30_rid_fwd_valid", inst_r_valid, 1); chk("t30_rid_fwd_data", inst_r_data, 32'hEE);
    chk("t30_rid_fwd_last", inst_r_last, 1);
    cyc; rvalid = 0; rlast = 0;
    smp; chk("t30_idle", rready, 0);
    cyc;

    // single-beat write, w before aw
    awready = 1; wready = 1; data_b_ready = 1;
    data_w_valid = 1; data_w_data = 32'hDEAD_BEEF; data_w_strb = 4'hF; data_w_last = 1;
    smp; chk("t31_w_before_aw", {wvalid, data_w_ready}, 0);
    cyc; data_aw_valid = 1; data_aw_addr = 32'h8000_1000; data_aw_len = 0; data_aw_size = 2;
    smp; chk("t31_widle_awvalid", awvalid, 0);
    cyc;
    smp;
    chk("t31_awvalid", awvalid, 1); chk("t31_awaddr", awaddr, 32'h8000_1000); chk("t31_awid", awid, 1);
    chk("t31_awlen", awlen, 0); chk("t31_awburst", awburst, 1); chk("t31_awconst", {awlock, awcache, awprot}, 0);
    chk("t31_wvalid", wvalid, 1); chk("t31_wdata", wdata, 32'hDEAD_BEEF); chk("t31_wstrb", wstrb, 4'hF);
    chk("t31_wlast", wlast, 1); chk("t31_wid", wid, 1);
    chk("t31_aw_ready", data_aw_ready, 1); chk("t31_w_ready", data_w_ready, 1);
    cyc; data_aw_valid = 0; data_w_valid = 0; data_w_last = 0;
    smp; chk("t31_resp_wait", {awvalid, wvalid, data_b_valid, bready}, 1);
    cyc; bvalid = 1; bresp = 2'b00; bid = 1;
    smp; chk("t31_b_valid", data_b_valid, 1); chk("t31_bready", bready, 1);
    cyc; bvalid = 0;
    smp; chk("t31_b_once", {data_b_valid, bready}, 0);
    cyc;

    // read with toggling r_ready concurrent with a 2-beat write
    data_ar_valid = 1; data_ar_addr = 32'h3000; data_ar_len = 3; data_ar_size = 2;
    data_aw_valid = 1; data_aw_addr = 32'h5000; data_aw_len = 1; data_aw_size = 2;
    arready = 1; data_w_strb = 4'h3;
    r_got = 0; rbeat = 0; wb = 0; b_cnt = 0; ar_seen = 0; aw_seen = 0; wl_seen = 0;
    cyc;
    for (int c = 0; c < 40 && !(r_got == 4 && b_cnt == 1); c++) begin
      data_ar_valid = !ar_seen; data_aw_valid = !aw_seen;
      data_r_ready = (c % 2 == 1);
      rvalid = ar_seen && (rbeat < 4); rid = 1; rdata = 32'hA0 + rbeat; rlast = (rbeat == 3);
      data_w_valid = (wb < 2); data_w_data = 32'h100 + wb; data_w_last = (wb == 1);
      bvalid = wl_seen && (b_cnt == 0);
      smp;
      if (data_ar_ready) ar_seen = 1;
      if (awvalid && awready) aw_seen = 1;
      if (data_r_valid && data_r_ready) begin
        chk("t32_r_data", data_r_data, 32'hA0 + r_got);
        chk("t32_r_last", data_r_last, (r_got == 3) ? 1 : 0);
        r_got++;
      end
      if (rvalid && rready) rbeat++;
      if (wvalid && wready) begin
        chk("t32_w_data", wdata, 32'h100 + wb);
        if (wlast) wl_seen = 1;
        wb++;
      end
      if (data_b_valid && data_b_ready) b_cnt++;
      cyc;
    end
    {data_ar_valid, data_aw_valid, rvalid, rlast, data_w_valid, data_w_last, bvalid, arready} = '0;
    chk("t32_r_beats", r_got, 4); chk("t32_slave_beats", rbeat, 4);
    chk("t32_w_beats", wb, 2); chk("t32_b_count", b_cnt, 1);
    smp; chk_quiet("t32_end_quiet");
    cyc;

    // reset in the middle of an 8-beat inst read
    inst_ar_valid = 1; inst_ar_addr = 32'hBFC0_0100; inst_ar_len = 7; arready = 1;
    smp; cyc;
    smp; chk("t33_ar_hs", inst_ar_ready, 1);
    cyc; inst_ar_valid = 0; arready = 0;
    for (int i = 0; i < 3; i++) begin
      rvalid = 1; rid = 0; rdata = 32'hF0 + i; rlast = 0; inst_r_ready = 1;
      smp; chk("t33_beat", inst_r_data, 32'hF0 + i);
      cyc;
    end
    rvalid = 0; reset = 1;
    smp; chk_quiet("t33_during");
    cyc; reset = 0;
    smp; chk_quiet("t33_after");
    cyc;
    data_ar_valid = 1; data_ar_addr = 32'h4000; data_ar_len = 0;
    smp; cyc; arready = 1;
    smp;
    chk("t33_new_arvalid", arvalid, 1); chk("t33_new_arid", arid, 1); chk("t33_new_araddr", araddr, 32'h4000);
    chk("t33_new_ar_ready", data_ar_ready, 1);
    cyc; data_ar_valid = 0; arready = 0;
    rvalid = 1; rid = 1; rdata = 32'h1234_5678; rlast = 1; data_r_ready = 1;
    smp;
    chk("t33_new_r_valid", data_r_valid, 1); chk("t33_new_r_data", data_r_data, 32'h1234_5678);
    chk("t33_new_r_last", data_r_last, 1); chk("t33_new_inst_quiet", inst_r_valid, 0);
    cyc; rvalid = 0; rlast = 0;
    smp; chk_quiet("t33_end");
    cyc;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_axi_arbiter.md
CACHE_AXI_ARBITER -- requirements
Module: cache_axi_arbiter

Interface
REQ-001 Parameter INST_ID, default 4'd0: AXI ID driven on arid for instruction-side reads.
REQ-002 Parameter DATA_ID, default 4'd1: AXI ID driven on arid/awid/wid for data-side transactions.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 inst_ar_valid/inst_ar_ready  in/out  1/1  icache read-request handshake.
REQ-006 inst_ar_addr/inst_ar_len/inst_ar_size  in  32/8/3  icache read address, burst length, beat size.
REQ-007 inst_r_valid/inst_r_ready/inst_r_data/inst_r_last  out/in/out/out  1/1/32/1  icache read-data beats.
REQ-008 data_ar_valid/ready, data_ar_addr/len/size, data_r_valid/ready/data/last  same widths and meaning as REQ-005..007, dcache side.
REQ-009 data_aw_valid/ready/addr/len/size, data_w_valid/ready/data/strb/last, data_b_valid/ready  in/out mix  1/1/32/8/3, 1/1/32/4/1, 1/1  dcache write channels.
REQ-010 AXI master ports ar*, r*, aw*, w*, b* at the widths of the core AXI interface (id 4, addr 32, len 8, size 3, burst 2, lock 2, cache 4, prot 3, data 32, strb 4, resp 2).

Function
REQ-011 Read FSM states: R_IDLE, R_ADDR, R_DATA; reset state R_IDLE; owner register (INST/DATA) resets to INST.
REQ-012 In R_IDLE, a request is granted the cycle any *_ar_valid is high; the winning request's addr/len/size and ID are captured in registers; next state R_ADDR.
REQ-013 Simultaneous inst and data requests: grant the side not granted last (round-robin); after reset, data wins first.
REQ-014 In R_ADDR, arvalid=1 with the captured fields; on arready the selected *_ar_ready pulses high for exactly that cycle; next state R_DATA.
REQ-015 *_ar_ready is 0 in every cycle other than REQ-014's handshake; the losing side's request stays pending, not dropped.
REQ-016 In R_DATA, rready = owner's *_r_ready; rvalid/rdata/rlast routed combinationally to the owner only; non-owner *_r_valid=0.
REQ-017 Beat with rvalid & rready & rlast returns FSM to R_IDLE; a new grant is possible the following cycle (R_IDLE lasts at least one cycle).
REQ-018 Response with rid != captured ID is still forwarded to the owner (single outstanding read).
REQ-019 Write FSM states: W_IDLE, W_ACTIVE, W_RESP; reset W_IDLE.
REQ-020 In W_IDLE, data_aw_valid moves to W_ACTIVE; in W_ACTIVE aw* and w* pass through combinationally to the data side; aw_done flag set on aw handshake; W_RESP is entered once aw_done is set (or aw handshakes this cycle) and a beat with wlast handshakes.
REQ-021 In W_RESP, bready = data_b_ready, data_b_valid = bvalid; b handshake returns to W_IDLE and clears aw_done.
REQ-022 Read and write FSMs are independent; no read/write address ordering is enforced.
REQ-023 Constants: arburst=awburst=2'b01, arlock=awlock=0, arcache=awcache=0, arprot=awprot=0.

Reset
REQ-024 During and one cycle after reset assertion: arvalid, awvalid, wvalid, rready, bready, all *_ready to caches, all *_valid to caches = 0.
REQ-025 Reset mid-burst abandons the transaction without draining; the bench shall not drive AXI responses across reset.

Structure
REQ-026 Shared package holds: read/write FSM state enums, AXI burst/size encodings, INST_ID/DATA_ID defaults.
REQ-027 One sub-module, axi_read_mux, implementing the R-channel owner routing (REQ-016); everything else inline.

Verification
REQ-028 Inst-only read addr 0xBFC00000 len 7 -> arid=0, araddr=0xBFC00000, 8 beats delivered to inst, last beat inst_r_last=1, FSM back to R_IDLE.
REQ-029 Inst and data ar_valid raised same cycle after reset -> data granted first (arid=1), inst granted the cycle after data's rlast+1.
REQ-030 arready held low 5 cycles -> arvalid and araddr stable throughout, *_ar_ready pulses once.
REQ-031 Data write addr 0x80001000 len 0 data 0xDEADBEEF strb 4'hF with wvalid before awvalid -> single aw and w handshake, bresp forwarded, data_b_valid one cycle.
REQ-032 Read in R_DATA with rready backpressure (owner r_ready toggling) concurrent with a write -> no lost/duplicated beats, write completes independently.
REQ-033 Reset asserted in R_DATA after beat 3 of 8 -> next cycle all valids/readies 0, FSMs idle, fresh request serviced normally.
